// File: rtl/mux21_rr_feeder.sv
// Round-robin burst arbiter feeding a 2:1 mux. Grant takes 1 idle cycle, then a beat lands in y 1 cycle after acceptance.
// Source ready drops whenever the registered output beat is held by downstream (y_valid & ~y_ready).
module mux21_rr_feeder #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             s,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [WIDTH-1:0] y_data,
    output logic             y_last,
    output logic             busy,
    output logic             trunc
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

    state_t           state_q, state_d;
    logic             last_served_q, last_served_d;
    logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
    logic             s_q, s_d;
    logic             y_valid_q, y_valid_d;
    logic [WIDTH-1:0] y_data_q, y_data_d;
    logic             y_last_q, y_last_d;
    logic             trunc_q, trunc_d;

    logic             out_free;
    logic             xfer;
    logic             cnt_hit;
    logic             burst_end;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;

    always_comb begin
        out_free  = ~y_valid_q | y_ready;
        a_ready   = (state_q == LOCK_A) & out_free;
        b_ready   = (state_q == LOCK_B) & out_free;
        xfer      = (a_valid & a_ready) | (b_valid & b_ready);
        sel_data  = (state_q == LOCK_B) ? b_data : a_data;
        sel_last  = (state_q == LOCK_B) ? b_last : a_last;
        cnt_hit   = (beat_cnt_q == CNT_LAST);
        burst_end = sel_last | cnt_hit;

        state_d       = state_q;
        last_served_d = last_served_q;
        beat_cnt_d    = beat_cnt_q;
        y_valid_d     = y_valid_q;
        y_data_d      = y_data_q;
        y_last_d      = y_last_q;
        trunc_d       = 1'b0;

        if (xfer) begin
            y_valid_d  = 1'b1;
            y_data_d   = sel_data;
            y_last_d   = burst_end;
            beat_cnt_d = beat_cnt_q + 1'b1;
            if (burst_end) begin
                state_d       = IDLE;
                last_served_d = (state_q == LOCK_B);
                beat_cnt_d    = '0;
                trunc_d       = ~sel_last;
            end
        end else if (y_ready) begin
            y_valid_d = 1'b0;
        end

        // last_served_q = 1 means B went last, so A wins a tie
        if (state_q == IDLE) begin
            if (a_valid & (~b_valid | last_served_q)) begin
                state_d = LOCK_A;
            end else if (b_valid) begin
                state_d = LOCK_B;
            end
        end

        s_d = (state_d == IDLE) ? s_q : (state_d == LOCK_B);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_served_q <= 1'b1;
            beat_cnt_q    <= '0;
            s_q           <= 1'b0;
            y_valid_q     <= 1'b0;
            y_data_q      <= '0;
            y_last_q      <= 1'b0;
            trunc_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            beat_cnt_q    <= beat_cnt_d;
            s_q           <= s_d;
            y_valid_q     <= y_valid_d;
            y_data_q      <= y_data_d;
            y_last_q      <= y_last_d;
            trunc_q       <= trunc_d;
        end
    end

    assign s       = s_q;
    assign y_valid = y_valid_q;
    assign y_data  = y_data_q;
    assign y_last  = y_last_q;
    assign busy    = (state_q != IDLE);
    assign trunc   = trunc_q;

endmodule

// File: tb/tb_mux21_rr_feeder.sv
// Bench for mux21_rr_feeder: directed scenarios plus randomized traffic scored against a beat-level model.
module tb_mux21_rr_feeder;

    localparam int W    = 8;
    localparam int MAXB = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         a_valid = 1'b0, a_last = 1'b0, b_valid = 1'b0, b_last = 1'b0;
    logic [W-1:0] a_data = '0, b_data = '0;
    logic         y_ready = 1'b0;
    logic         a_ready, b_ready, s, y_valid, y_last, busy, trunc;
    logic [W-1:0] y_data;

    mux21_rr_feeder #(.WIDTH(W), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_last(b_last),
        .s(s), .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_last(y_last),
        .busy(busy), .trunc(trunc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t aq[$], bq[$], seen[$];
    int    checks = 0;
    int    errors = 0;

    // model: 0 idle, 1 A granted, 2 B granted; ls = source that finished last (0 A, 1 B)
    int    st, ls, cnt;
    logic  es, et, ov;
    beat_t ob;
    int    trunc_cnt;
    int    a_pct, b_pct, y_pct;
    bit    gen_en;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic beat_t mk(input logic [7:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        return b;
    endfunction

    task automatic model_reset();
        st = 0; ls = 1; cnt = 0; es = 1'b0; et = 1'b0; ov = 1'b0; ob = '0;
    endtask

    task automatic gen_burst(input bit src);
        int    n;
        bit    endl;
        beat_t bt;
        n    = $urandom_range(7, 1);
        endl = ($urandom_range(99) < 85);
        for (int i = 0; i < n; i++) begin
            bt.d = 8'($urandom);
            bt.l = (i == n - 1) && endl;
            if (src) bq.push_back(bt);
            else     aq.push_back(bt);
        end
    endtask

    task automatic drive();
        if (gen_en && aq.size() == 0 && $urandom_range(2) == 0) gen_burst(1'b0);
        if (gen_en && bq.size() == 0 && $urandom_range(2) == 0) gen_burst(1'b1);
        a_valid = (aq.size() > 0) && ($urandom_range(99) < a_pct);
        b_valid = (bq.size() > 0) && ($urandom_range(99) < b_pct);
        if (aq.size() > 0) begin a_data = aq[0].d; a_last = aq[0].l; end
        else begin a_data = 8'($urandom); a_last = 1'($urandom); end
        if (bq.size() > 0) begin b_data = bq[0].d; b_last = bq[0].l; end
        else begin b_data = 8'($urandom); b_last = 1'($urandom); end
        y_ready = ($urandom_range(99) < y_pct);
    endtask

    task automatic model_step();
        bit    rdy, acc_a, acc_b;
        beat_t bt;
        int    pst;
        chk("busy", busy, st != 0);
        chk("s", s, es);
        chk("trunc", trunc, et);
        chk("y_valid", y_valid, ov);
        if (ov) begin
            chk("y_data", y_data, ob.d);
            chk("y_last", y_last, ob.l);
        end
        rdy = !ov || y_ready;
        chk("a_ready", a_ready, (st == 1) && rdy);
        chk("b_ready", b_ready, (st == 2) && rdy);
        if (y_valid && y_ready) seen.push_back({y_data, y_last});
        if (trunc) trunc_cnt++;

        acc_a = (st == 1) && a_valid && rdy;
        acc_b = (st == 2) && b_valid && rdy;
        pst = st;
        et  = 1'b0;
        if (acc_a || acc_b) begin
            bt   = acc_a ? aq.pop_front() : bq.pop_front();
            cnt++;
            ov   = 1'b1;
            ob.d = bt.d;
            ob.l = bt.l || (cnt == MAXB);
            if (ob.l) begin
                et  = !bt.l;
                ls  = acc_b ? 1 : 0;
                st  = 0;
                cnt = 0;
            end
        end else if (y_ready) begin
            ov = 1'b0;
        end
        if (pst == 0) begin
            if (a_valid && (!b_valid || ls == 1)) st = 1;
            else if (b_valid)                     st = 2;
        end
        if (st != 0) es = (st == 2);
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("rst_y_valid", y_valid, 0);
        chk("rst_y_data", y_data, 0);
        chk("rst_y_last", y_last, 0);
        chk("rst_s", s, 0);
        chk("rst_busy", busy, 0);
        chk("rst_trunc", trunc, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        model_reset();
        aq.delete();
        bq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        beat_t e[$];
        int    g[$];
        bit    prev_busy, rst_done, found;

        gen_en = 1'b0; a_pct = 100; b_pct = 0; y_pct = 100; trunc_cnt = 0;
        model_reset();
        #2;
        do_reset();

        // single source A, 3-beat burst, first beat visible two edges after valid
        aq = '{mk(8'h11, 1'b0), mk(8'h22, 1'b0), mk(8'h33, 1'b1)};
        seen.delete();
        drive(); tick();
        chk("t2_busy", busy, 1);
        chk("t2_yv_early", y_valid, 0);
        drive(); tick();
        chk("t2_yv", y_valid, 1);
        chk("t2_first", y_data, 8'h11);
        repeat (6) begin drive(); tick(); end
        e = '{mk(8'h11, 1'b0), mk(8'h22, 1'b0), mk(8'h33, 1'b1)};
        chk("t2_count", seen.size(), e.size());
        for (int i = 0; i < e.size() && i < seen.size(); i++) chk("t2_beat", seen[i], e[i]);

        // watchdog: 6 beats from A with last only on the 6th, B arrives while A is locked
        aq.delete();
        for (int i = 1; i <= 6; i++) aq.push_back(mk(8'hA0 + 8'(i), i == 6));
        bq = '{mk(8'hB1, 1'b1)};
        seen.delete();
        trunc_cnt = 0;
        a_pct = 100; b_pct = 0;
        drive(); tick();
        b_pct = 100;
        repeat (13) begin drive(); tick(); end
        e = '{mk(8'hA1, 1'b0), mk(8'hA2, 1'b0), mk(8'hA3, 1'b0), mk(8'hA4, 1'b1),
              mk(8'hB1, 1'b1), mk(8'hA5, 1'b0), mk(8'hA6, 1'b1)};
        chk("t5_count", seen.size(), e.size());
        for (int i = 0; i < e.size() && i < seen.size(); i++) chk("t5_beat", seen[i], e[i]);
        chk("t5_trunc_pulses", trunc_cnt, 1);

        // round robin from reset with both sources continuously valid
        do_reset();
        for (int i = 0; i < 3; i++) begin
            aq.push_back(mk(8'(8'h40 + i), 1'b0)); aq.push_back(mk(8'(8'h50 + i), 1'b1));
            bq.push_back(mk(8'(8'h60 + i), 1'b0)); bq.push_back(mk(8'(8'h70 + i), 1'b1));
        end
        a_pct = 100; b_pct = 100; y_pct = 100;
        prev_busy = 1'b0;
        repeat (20) begin
            drive(); tick();
            if (busy && !prev_busy) g.push_back(s);
            prev_busy = busy;
        end
        chk("t3_grants", g.size(), 6);
        for (int i = 0; i < g.size(); i++) chk("t3_grant_sel", g[i], i % 2);

        // random traffic with backpressure and a reset in the middle of a burst
        gen_en   = 1'b1;
        rst_done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                a_pct = $urandom_range(100, 20);
                b_pct = $urandom_range(100, 20);
                y_pct = $urandom_range(100, 30);
            end
            drive(); tick();
            if (i >= 1500 && !rst_done && busy) begin
                do_reset();
                rst_done = 1'b1;
            end
        end
        chk("midburst_reset_hit", rst_done, 1);

        // gap hold: B locked, b_valid low for 10 cycles while A requests
        a_pct = 100; b_pct = 100; y_pct = 100;
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            drive(); tick();
            found = busy && s;
        end
        chk("t6_lock_found", found, 1);
        if (found) begin
            b_pct = 0;
            for (int k = 0; k < 10; k++) begin
                if (aq.size() == 0) gen_burst(1'b0);
                drive(); tick();
                chk("t6_busy", busy, 1);
                chk("t6_s", s, 1);
                chk("t6_a_ready", a_ready, 0);
            end
            b_pct = 100;
        end
        repeat (200) begin drive(); tick(); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
